muldiv_alu_controller: RTL
==========================

MULDIV_ALU_CONTROLLER -- requirements
Module: muldiv_alu_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (even, >=8).
REQ-002 SHALL have parameter ENABLE_M, default 1, M-extension enable; 0 decodes all M ops as illegal.
REQ-003 SHALL have ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any operation
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid&&in_ready
- alu_op  input  2  main-decoder class
- funct7  input  7  instruction funct7
- funct3  input  3  instruction funct3
- src_a  input  XLEN  operand A
- src_b  input  XLEN  operand B
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid&&out_ready
- result  output  XLEN  registered result
- operation  output  4  registered decoded op code
- zero  output  1  result==0
- illegal  output  1  decoded op unsupported
- busy  output  1  multi-cycle op in progress

Function
REQ-004 Decode SHALL be sampled only on acceptance: alu_op 00 -> ADD; 01 -> SUB; 11 -> ADD.
REQ-005 alu_op 10, funct7 0000000, funct3 -> op codes:
- 000 ADD 0010; 001 SLL 0111; 010 SLT 0011; 100 XOR 1100; 101 SRL 0100; 110 OR 0001; 111 AND 0000.
REQ-006 alu_op 10, funct7 0100000: funct3 000 SUB 0110; funct3 101 SRA 0101.
REQ-007 alu_op 10, funct7 0000001, funct3 -> op codes:
- 000 MUL 1000; 011 MULHU 1001; 100 DIV 1010; 101 DIVU 1011; 110 REM 1101; 111 REMU 1110.
REQ-008 Any other alu_op 10 combination SHALL give operation 1111, illegal=1, result 0, latency 1.
REQ-009 Shift amount SHALL be src_b[$clog2(XLEN)-1:0]; SLT signed; arithmetic wraps modulo 2^XLEN.
REQ-010 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-011 in_ready SHALL be 1 only in IDLE with out_valid=0, or in DONE with out_ready=1.
REQ-012 Single-cycle ops SHALL go directly to DONE; out_valid rises the cycle after acceptance (latency 1).
REQ-013 MUL/MULHU SHALL use an iterative shift-add multiplier, one bit per cycle, XLEN cycles in MUL; out_valid at acceptance+XLEN+1.
REQ-014 MUL SHALL return the low XLEN bits; MULHU the high XLEN bits of the unsigned 2*XLEN product.
REQ-015 DIV/DIVU/REM/REMU SHALL use restoring division, XLEN cycles in DIV; out_valid at acceptance+XLEN+1.
REQ-016 Signed division SHALL run on magnitudes; quotient is negated when operand signs differ, remainder takes dividend sign.
REQ-017 src_b==0 SHALL bypass the DIV state (latency 1): quotient all ones, remainder = src_a.
REQ-018 Signed overflow (src_a=MIN, src_b=-1) SHALL bypass the DIV state (latency 1): quotient = MIN, remainder 0.
REQ-019 busy SHALL be 1 exactly in MUL and DIV states.
REQ-020 In DONE, result/operation/zero/illegal SHALL hold stable until out_ready; without a new acceptance the FSM then goes to IDLE and out_valid drops.
REQ-021 A new acceptance in the same cycle as out_ready (back-to-back) SHALL load the new op with no idle cycle.
REQ-022 flush SHALL, next edge, force IDLE, out_valid=0, busy=0, discard partial state; flush overrides simultaneous acceptance.
REQ-023 Inputs src_a/src_b/funct fields SHALL be captured at acceptance; later changes do not affect the result.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, out_valid=0, busy=0, illegal=0, result=0, operation=0000, zero=1.
REQ-025 Reset asserted mid-operation SHALL abort it; the first acceptance is possible on the first edge after rst_n rises.

Verification
REQ-026 ADD 7+5 (alu_op 10, f7 0, f3 000), out_ready=1 -> result 12, operation 0010, out_valid one cycle later.
REQ-027 DIV -7/2 (XLEN 32) -> after 33 cycles result 0xFFFFFFFD, busy high 32 cycles; REM -> 0xFFFFFFFF.
REQ-028 DIVU 5/0 -> latency 1, result 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-029 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-030 out_ready held 0 for 5 cycles -> result stable, in_ready 0; flush during MUL -> out_valid stays 0, in_ready 1 next cycle.
REQ-031 funct7 0000001 f3 001 -> illegal=1, operation 1111, result 0; rst_n pulsed mid-DIV -> all outputs at reset values immediately.

Source files
------------

// File: rtl/muldiv_alu_controller.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_alu_controller
// Brief    : RV-style ALU controller. It decodes alu_op/funct7/funct3 into an
//            op code, executes single-cycle ALU ops, and runs iterative
//            shift-add multiply and restoring divide. Valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_alu_controller #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      operation,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int              c_CW   = $clog2(XLEN);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);
  localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [3:0] c_OP_AND   = 4'b0000;
  localparam logic [3:0] c_OP_OR    = 4'b0001;
  localparam logic [3:0] c_OP_ADD   = 4'b0010;
  localparam logic [3:0] c_OP_SLT   = 4'b0011;
  localparam logic [3:0] c_OP_SRL   = 4'b0100;
  localparam logic [3:0] c_OP_SRA   = 4'b0101;
  localparam logic [3:0] c_OP_SUB   = 4'b0110;
  localparam logic [3:0] c_OP_SLL   = 4'b0111;
  localparam logic [3:0] c_OP_MUL   = 4'b1000;
  localparam logic [3:0] c_OP_MULHU = 4'b1001;
  localparam logic [3:0] c_OP_DIV   = 4'b1010;
  localparam logic [3:0] c_OP_DIVU  = 4'b1011;
  localparam logic [3:0] c_OP_XOR   = 4'b1100;
  localparam logic [3:0] c_OP_REM   = 4'b1101;
  localparam logic [3:0] c_OP_REMU  = 4'b1110;
  localparam logic [3:0] c_OP_ILL   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_state_next, w_target;

  logic [3:0]        w_op;
  logic              w_illegal;
  logic [c_CW-1:0]   w_shamt;
  logic              w_is_mul, w_is_div, w_signed_div, w_is_rem;
  logic              w_div_zero, w_div_ovf, w_fast;
  logic [XLEN-1:0]   w_fast_res, w_a_mag, w_b_mag;
  logic              w_accept;

  logic [3:0]        r_op;
  logic              r_illegal;
  logic [XLEN-1:0]   r_result;
  logic [c_CW-1:0]   r_cnt;
  logic [2*XLEN-1:0] r_p;
  logic [XLEN-1:0]   r_mcand;
  logic              r_hi;
  logic [XLEN-1:0]   r_rem, r_quo, r_div;
  logic              r_neg_q, r_neg_r, r_rem_sel;

  // Decode the request fields into an op code; anything unlisted is illegal.
  always_comb begin
    w_op      = c_OP_ILL;
    w_illegal = 1'b0;
    case (alu_op)
      2'b01: w_op = c_OP_SUB;
      2'b10: begin
        w_illegal = 1'b1;
        if (funct7 == 7'b0000000) begin
          w_illegal = 1'b0;
          case (funct3)
            3'b000:  w_op = c_OP_ADD;
            3'b001:  w_op = c_OP_SLL;
            3'b010:  w_op = c_OP_SLT;
            3'b100:  w_op = c_OP_XOR;
            3'b101:  w_op = c_OP_SRL;
            3'b110:  w_op = c_OP_OR;
            3'b111:  w_op = c_OP_AND;
            default: w_illegal = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            w_op      = c_OP_SUB;
            w_illegal = 1'b0;
          end else if (funct3 == 3'b101) begin
            w_op      = c_OP_SRA;
            w_illegal = 1'b0;
          end
        end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
          w_illegal = 1'b0;
          case (funct3)
            3'b000:  w_op = c_OP_MUL;
            3'b011:  w_op = c_OP_MULHU;
            3'b100:  w_op = c_OP_DIV;
            3'b101:  w_op = c_OP_DIVU;
            3'b110:  w_op = c_OP_REM;
            3'b111:  w_op = c_OP_REMU;
            default: w_illegal = 1'b1;
          endcase
        end
      end
      default: w_op = c_OP_ADD;
    endcase
  end

  assign w_shamt      = src_b[c_CW-1:0];
  assign w_is_mul     = (w_op == c_OP_MUL) || (w_op == c_OP_MULHU);
  assign w_signed_div = (w_op == c_OP_DIV) || (w_op == c_OP_REM);
  assign w_is_rem     = (w_op == c_OP_REM) || (w_op == c_OP_REMU);
  assign w_is_div     = w_signed_div || (w_op == c_OP_DIVU) || (w_op == c_OP_REMU);
  assign w_div_zero   = (src_b == '0);
  assign w_div_ovf    = w_signed_div && (src_a == c_MIN) && (src_b == '1);
  assign w_fast       = w_is_div && (w_div_zero || w_div_ovf);
  assign w_a_mag      = (w_signed_div && src_a[XLEN-1]) ? -src_a : src_a;
  assign w_b_mag      = (w_signed_div && src_b[XLEN-1]) ? -src_b : src_b;

  // Single-cycle result, including the divide-by-zero and overflow shortcuts.
  always_comb begin
    w_fast_res = '0;
    case (w_op)
      c_OP_ADD: w_fast_res = src_a + src_b;
      c_OP_SUB: w_fast_res = src_a - src_b;
      c_OP_SLL: w_fast_res = src_a << w_shamt;
      c_OP_SLT: w_fast_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      c_OP_XOR: w_fast_res = src_a ^ src_b;
      c_OP_SRL: w_fast_res = src_a >> w_shamt;
      c_OP_SRA: w_fast_res = $unsigned($signed(src_a) >>> w_shamt);
      c_OP_OR:  w_fast_res = src_a | src_b;
      c_OP_AND: w_fast_res = src_a & src_b;
      default:  w_fast_res = '0;
    endcase
    if (w_is_div && w_div_zero)
      w_fast_res = w_is_rem ? src_a : '1;
    else if (w_div_ovf)
      w_fast_res = w_is_rem ? '0 : c_MIN;
  end

  // One shift-add multiplier step: add multiplicand to the high half, shift right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_p_next;
  assign w_mul_sum = {1'b0, r_p[2*XLEN-1:XLEN]} + {1'b0, (r_p[0] ? r_mcand : '0)};
  assign w_p_next  = {w_mul_sum, r_p[XLEN-1:1]};

  // One restoring-division step on magnitudes.
  logic [XLEN:0]   w_rem_shift;
  logic [XLEN-1:0] w_diff, w_rem_next, w_quo_next, w_div_res;
  logic            w_diff_ok;
  assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff_ok   = (w_rem_shift >= {1'b0, r_div});
  assign w_diff      = w_rem_shift[XLEN-1:0] - r_div;
  assign w_rem_next  = w_diff_ok ? w_diff : w_rem_shift[XLEN-1:0];
  assign w_quo_next  = {r_quo[XLEN-2:0], w_diff_ok};
  assign w_div_res   = r_rem_sel ? (r_neg_r ? -w_rem_next : w_rem_next)
                                 : (r_neg_q ? -w_quo_next : w_quo_next);

  // Handshake outputs and next-state selection; flush wins over everything.
  always_comb begin
    in_ready     = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    out_valid    = (r_state == S_DONE);
    busy         = (r_state == S_MUL) || (r_state == S_DIV);
    w_accept     = in_valid && in_ready && !flush;
    w_target     = w_is_mul ? S_MUL : ((w_is_div && !w_fast) ? S_DIV : S_DONE);
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_target;
      S_MUL:  if (r_cnt == c_LAST) w_state_next = S_DONE;
      S_DIV:  if (r_cnt == c_LAST) w_state_next = S_DONE;
      S_DONE: begin
        if (w_accept)
          w_state_next = w_target;
        else if (out_ready)
          w_state_next = S_IDLE;
      end
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Datapath: capture operands on acceptance, then iterate one bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_op      <= 4'b0000;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      r_p       <= '0;
      r_mcand   <= '0;
      r_hi      <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rem_sel <= 1'b0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_illegal <= w_illegal;
      r_cnt     <= '0;
      r_p       <= {{XLEN{1'b0}}, src_a};
      r_mcand   <= src_b;
      r_hi      <= (w_op == c_OP_MULHU);
      r_rem     <= '0;
      r_quo     <= w_a_mag;
      r_div     <= w_b_mag;
      r_neg_q   <= w_signed_div && (src_a[XLEN-1] ^ src_b[XLEN-1]);
      r_neg_r   <= w_signed_div && src_a[XLEN-1];
      r_rem_sel <= w_is_rem;
      if (w_target == S_DONE) r_result <= w_fast_res;
    end else if (!flush) begin
      if (r_state == S_MUL) begin
        r_p   <= w_p_next;
        r_cnt <= r_cnt + c_CW'(1);
        if (r_cnt == c_LAST)
          r_result <= r_hi ? w_p_next[2*XLEN-1:XLEN] : w_p_next[XLEN-1:0];
      end else if (r_state == S_DIV) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        r_cnt <= r_cnt + c_CW'(1);
        if (r_cnt == c_LAST) r_result <= w_div_res;
      end
    end
  end

  assign result    = r_result;
  assign operation = r_op;
  assign illegal   = r_illegal;
  assign zero      = (r_result == '0);

endmodule
`default_nettype wire
